// File: rtl/vec_pipe_chain.sv
// vec_pipe_chain: elastic multi-lane pipeline with flush, occupancy count and register-forwarding lookup
module vec_pipe_chain #(
  parameter int LANES = 3,
  parameter int WIDTH = 18,
  parameter int DEPTH = 3,
  parameter int RADDR = 4
)(
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       in_data,
  input  logic [RADDR-1:0]             in_wa,
  input  logic                         in_we,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [RADDR-1:0]             out_wa,
  output logic                         out_we,
  input  logic                         flush,
  input  logic [RADDR-1:0]             fwd_ra1,
  input  logic [RADDR-1:0]             fwd_ra2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [LANES*WIDTH-1:0]       fwd_data1,
  output logic [LANES*WIDTH-1:0]       fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);
  localparam int DW = LANES*WIDTH;
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] valid_q, valid_d, we_q, we_d, rdy;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [RADDR-1:0] wa_q [DEPTH];
  logic [RADDR-1:0] wa_d [DEPTH];
  logic [OW-1:0]    occ_q, occ_d;
  logic             in_xfer, out_xfer;
  // ready ripples back from the output: a stage may load if it is empty or its successor moves
  always_comb begin : ready_chain
    logic r;
    r = out_ready;
    for (int k = DEPTH-1; k >= 0; k--) begin
      r = !valid_q[k] || r;
      rdy[k] = r;
    end
  end
  assign in_ready  = rdy[0] && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = valid_q[DEPTH-1] && out_ready && !flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_wa    = wa_q[DEPTH-1];
  assign out_we    = we_q[DEPTH-1];
  assign occ       = occ_q;
  // stage advance; payload only moves with a valid entry, flush kills every valid bit
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    data_d  = data_q;
    wa_d    = wa_q;
    if (rdy[0]) valid_d[0] = in_xfer;
    if (in_xfer) begin
      data_d[0] = in_data;
      wa_d[0]   = in_wa;
      we_d[0]   = in_we;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) valid_d[k] = valid_q[k-1];
      if (rdy[k] && valid_q[k-1]) begin
        data_d[k] = data_q[k-1];
        wa_d[k]   = wa_q[k-1];
        we_d[k]   = we_q[k-1];
      end
    end
    if (flush) valid_d = '0;
  end
  // occupancy tracks accepted minus released entries
  always_comb occ_d = flush ? '0 : occ_q + OW'(in_xfer) - OW'(out_xfer);
  // forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (valid_q[k] && we_q[k] && wa_q[k] == fwd_ra1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[k];
      end
      if (valid_q[k] && we_q[k] && wa_q[k] == fwd_ra2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[k];
      end
    end
  end
  // pipeline state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= '0;
      we_q    <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        wa_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      occ_q   <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
        wa_q[k]   <= wa_d[k];
      end
    end
  end
endmodule

// File: tb/tb_vec_pipe_chain.sv
// tb_vec_pipe_chain: table-driven, directed and randomized checks of vec_pipe_chain against a queue model
module tb_vec_pipe_chain;
  localparam int L = 3, W = 18, D = 3, R = 4, DW = L*W;
  logic CLK = 1'b0, RST;
  logic in_valid, in_ready, in_we, out_valid, out_ready, out_we, flush;
  logic [DW-1:0] in_data, out_data, fwd_data1, fwd_data2;
  logic [R-1:0] in_wa, out_wa, fwd_ra1, fwd_ra2;
  logic fwd_hit1, fwd_hit2;
  logic [1:0] occ;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_we, s_fh1, s_fh2;
  logic [DW-1:0] s_in_data, s_out_data, s_fd1, s_fd2;
  logic [R-1:0] s_out_wa;
  logic [0:0] s_occ;
  int checks = 0, errors = 0;
  typedef struct { logic iv; logic [W-1:0] d; logic ordy; logic ev; logic [W-1:0] eo; logic eir; logic [1:0] eocc; } vec_t;
  typedef struct { logic [DW-1:0] data; logic [R-1:0] wa; logic we; } ent_t;
  vec_t tbl[$];
  ent_t mq[$];
  always #5 CLK = ~CLK;
  vec_pipe_chain #(.LANES(L), .WIDTH(W), .DEPTH(D), .RADDR(R)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_wa(in_wa), .in_we(in_we), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_wa(out_wa), .out_we(out_we), .flush(flush),
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .occ(occ));
  vec_pipe_chain #(.LANES(L), .WIDTH(W), .DEPTH(1), .RADDR(R)) dut1 (
    .CLK(CLK), .RST(RST), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_wa('0), .in_we(1'b0), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_data(s_out_data), .out_wa(s_out_wa), .out_we(s_out_we), .flush(1'b0),
    .fwd_ra1('0), .fwd_ra2('0), .fwd_hit1(s_fh1), .fwd_hit2(s_fh2),
    .fwd_data1(s_fd1), .fwd_data2(s_fd2), .occ(s_occ));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] mk(input logic [W-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = v ^ W'(i << 8);
    return r;
  endfunction
  task automatic idle();
    in_valid = 0; in_data = '0; in_wa = '0; in_we = 0; out_ready = 0; flush = 0;
  endtask
  task automatic add(input logic iv, input int d, input logic o, input logic ev, input int eo, input logic eir, input int eocc);
    tbl.push_back('{iv, W'(d), o, ev, W'(eo), eir, 2'(eocc)});
  endtask
  task automatic do_flush();
    flush = 1; @(negedge CLK); flush = 0;
  endtask
  task automatic model_step();
    logic eir, h1, h2;
    logic [DW-1:0] d1, d2;
    #1;
    eir = (mq.size() < D || out_ready) && !flush;
    chk("rnd in_ready", 64'(in_ready), 64'(eir));
    chk("rnd occ", 64'(occ), 64'(mq.size()));
    if (mq.size() == D) chk("rnd full out_valid", 64'(out_valid), 64'd1);
    if (out_valid) begin
      if (mq.size() == 0) chk("rnd spurious out_valid", 64'(out_valid), 64'd0);
      else begin
        chk("rnd out_data", 64'(out_data), 64'(mq[0].data));
        chk("rnd out_wa", 64'(out_wa), 64'(mq[0].wa));
        chk("rnd out_we", 64'(out_we), 64'(mq[0].we));
      end
    end
    h1 = 0; h2 = 0; d1 = '0; d2 = '0;
    foreach (mq[i]) begin
      if (mq[i].we && mq[i].wa == fwd_ra1) begin h1 = 1; d1 = mq[i].data; end
      if (mq[i].we && mq[i].wa == fwd_ra2) begin h2 = 1; d2 = mq[i].data; end
    end
    chk("rnd fwd_hit1", 64'(fwd_hit1), 64'(h1));
    chk("rnd fwd_data1", 64'(fwd_data1), 64'(d1));
    chk("rnd fwd_hit2", 64'(fwd_hit2), 64'(h2));
    chk("rnd fwd_data2", 64'(fwd_data2), 64'(d2));
    if (flush) mq.delete();
    else begin
      if (out_valid && out_ready && mq.size() > 0) void'(mq.pop_front());
      if (in_valid && eir) mq.push_back('{in_data, in_wa, in_we});
    end
    @(negedge CLK);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    RST = 0; idle(); fwd_ra1 = 0; fwd_ra2 = 0; s_in_valid = 0; s_in_data = '0;
    add(1, 1, 1, 0, 0, 1, 0);   add(1, 2, 1, 0, 0, 1, 1);   add(1, 3, 1, 0, 0, 1, 2);
    add(1, 4, 1, 1, 1, 1, 3);   add(0, 0, 1, 1, 2, 1, 3);   add(0, 0, 1, 1, 3, 1, 2);
    add(0, 0, 1, 1, 4, 1, 1);   add(1, 10, 0, 0, 0, 1, 0);  add(1, 11, 0, 0, 0, 1, 1);
    add(1, 12, 0, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++) add(1, 99, 0, 1, 10, 0, 3);
    add(0, 0, 1, 1, 10, 1, 3);  add(0, 0, 1, 1, 11, 1, 2);  add(0, 0, 1, 1, 12, 1, 1);
    add(0, 0, 1, 0, 0, 1, 0);
    @(negedge CLK); #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset occ", 64'(occ), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset fwd_hit1", 64'(fwd_hit1), 64'd0);
    chk("reset fwd_hit2", 64'(fwd_hit2), 64'd0);
    chk("reset d1 out_valid", 64'(s_out_valid), 64'd0);
    @(negedge CLK); RST = 1; @(negedge CLK);
    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = mk(tbl[i].d); out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
      chk($sformatf("tbl[%0d] occ", i), 64'(occ), 64'(tbl[i].eocc));
      if (tbl[i].ev) chk($sformatf("tbl[%0d] lane0", i), 64'(out_data[W-1:0]), 64'(tbl[i].eo));
      @(negedge CLK);
    end
    idle();
    in_valid = 1; in_data = mk(20); @(negedge CLK);
    in_valid = 0; @(negedge CLK);
    in_valid = 1; in_data = mk(21); @(negedge CLK);
    in_valid = 0; @(negedge CLK); @(negedge CLK); #1;
    chk("bubble occ", 64'(occ), 64'd2);
    chk("bubble out_valid", 64'(out_valid), 64'd1);
    chk("bubble lane0 A", 64'(out_data[W-1:0]), 64'd20);
    out_ready = 1; #1;
    chk("bubble in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK); #1;
    chk("bubble B no gap valid", 64'(out_valid), 64'd1);
    chk("bubble B no gap lane0", 64'(out_data[W-1:0]), 64'd21);
    @(negedge CLK); #1;
    chk("bubble drained", 64'(occ), 64'd0);
    idle();
    in_valid = 1; in_wa = 5; in_we = 1; in_data = mk(7); @(negedge CLK);
    in_data = mk(9); @(negedge CLK);
    idle(); fwd_ra1 = 5; fwd_ra2 = 6; #1;
    chk("fwd hit1", 64'(fwd_hit1), 64'd1);
    chk("fwd data1 youngest", 64'(fwd_data1), 64'(mk(9)));
    chk("fwd hit2 miss", 64'(fwd_hit2), 64'd0);
    chk("fwd data2 miss", 64'(fwd_data2), 64'd0);
    @(negedge CLK); #1;
    chk("fwd data1 after shift", 64'(fwd_data1), 64'(mk(9)));
    do_flush(); #1;
    chk("fwd hit1 after flush", 64'(fwd_hit1), 64'd0);
    in_valid = 1; in_wa = 5; in_we = 0; in_data = mk(7); @(negedge CLK);
    idle(); #1;
    chk("fwd we0 occ", 64'(occ), 64'd1);
    chk("fwd we0 no hit", 64'(fwd_hit1), 64'd0);
    chk("fwd we0 data", 64'(fwd_data1), 64'd0);
    do_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = mk(W'(30 + i)); @(negedge CLK);
    end
    idle(); #1;
    chk("flush pre occ", 64'(occ), 64'd3);
    in_valid = 1; in_data = mk(40); out_ready = 1; flush = 1; #1;
    chk("flush in_ready", 64'(in_ready), 64'd0);
    @(negedge CLK); idle(); #1;
    chk("flush occ", 64'(occ), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    in_valid = 1; in_data = mk(41); out_ready = 1; @(negedge CLK);
    in_valid = 0; @(negedge CLK); @(negedge CLK); #1;
    chk("post flush valid", 64'(out_valid), 64'd1);
    chk("post flush lane0", 64'(out_data[W-1:0]), 64'd41);
    @(negedge CLK); idle();
    in_valid = 1; in_wa = 3; in_we = 1; in_data = mk(50); @(negedge CLK);
    in_data = mk(51); @(negedge CLK);
    idle(); fwd_ra1 = 3; fwd_ra2 = 3; #1;
    chk("areset pre occ", 64'(occ), 64'd2);
    chk("areset pre hit", 64'(fwd_hit1), 64'd1);
    @(posedge CLK); #2; RST = 0; #1;
    chk("areset out_valid", 64'(out_valid), 64'd0);
    chk("areset occ", 64'(occ), 64'd0);
    chk("areset hit1", 64'(fwd_hit1), 64'd0);
    chk("areset hit2", 64'(fwd_hit2), 64'd0);
    chk("areset out_data", 64'(out_data), 64'd0);
    @(negedge CLK); RST = 1;
    s_in_valid = 1; s_in_data = mk(60); #1;
    chk("d1 in_ready", 64'(s_in_ready), 64'd1);
    @(negedge CLK); s_in_valid = 0; #1;
    chk("d1 out_valid", 64'(s_out_valid), 64'd1);
    chk("d1 lane0", 64'(s_out_data[W-1:0]), 64'd60);
    chk("d1 occ", 64'(s_occ), 64'd1);
    @(negedge CLK); #1;
    chk("d1 drained", 64'(s_out_valid), 64'd0);
    in_valid = 1; in_data = mk(70); out_ready = 1; @(negedge CLK);
    in_valid = 0; @(negedge CLK); #1;
    chk("post reset not early", 64'(out_valid), 64'd0);
    @(negedge CLK); #1;
    chk("post reset latency", 64'(out_valid), 64'd1);
    chk("post reset lane0", 64'(out_data[W-1:0]), 64'd70);
    @(negedge CLK); idle(); mq.delete();
    for (int n = 0; n < 1500; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = DW'({$urandom, $urandom});
      in_wa = R'($urandom_range(0, 3));
      in_we = 1'($urandom);
      out_ready = (n % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = $urandom_range(0, 40) == 0;
      fwd_ra1 = R'($urandom_range(0, 3));
      fwd_ra2 = R'($urandom_range(0, 3));
      model_step();
    end
    idle(); out_ready = 1;
    for (int n = 0; n < D + 2; n++) model_step();
    chk("drain model empty", 64'(mq.size()), 64'd0);
    chk("drain occ", 64'(occ), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
